// File: rtl/kv_pkg.sv
// Shared definitions for the KV request path: request-header layout, framer
// states and the opcode values also used by request_parser.
package kv_pkg;

  localparam logic [15:0] HDR_MAGIC    = 16'hFFFF;
  localparam int          HDR_BITS     = 128;
  localparam int          CLI_HDR_BITS = 32;
  localparam int          SHIFT_BITS   = 96;

  localparam logic [7:0]  OP_GET       = 8'h00;
  localparam logic [7:0]  OP_SET       = 8'h01;

  localparam logic [7:0]  KEYLEN_WORDS_OK = 8'd1;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_BODY  = 2'd1,
    ST_TAIL  = 2'd2,
    ST_DROP  = 2'd3
  } kv_state_t;

  // Client header {totlen, keylen, opcode} plus connection meta -> request header.
  function automatic logic [HDR_BITS-1:0] build_req_hdr(
    input logic [63:0]           meta,
    input logic [CLI_HDR_BITS-1:0] cli
  );
    return {meta, cli[7:0], cli[15:8], cli[31:16], 16'h0000, HDR_MAGIC};
  endfunction

endpackage

// File: rtl/kv_request_framer.sv
// Rewrites UDP payload packets into request_parser's 128-bit header format,
// realigning the payload 96 bits upward and dropping malformed packets.
module kv_request_framer
  import kv_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int META_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic [META_WIDTH-1:0]   s_axis_tuser,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [31:0]             drop_count
);

  localparam int KEEP_WIDTH    = DATA_WIDTH / 8;
  localparam int SHIFT_BYTES   = SHIFT_BITS / 8;
  localparam int CLI_HDR_BYTES = CLI_HDR_BITS / 8;
  localparam int HDR_BYTES     = HDR_BITS / 8;
  localparam int CARRY_LSB     = DATA_WIDTH - SHIFT_BITS;
  localparam int CARRY_KLSB    = KEEP_WIDTH - SHIFT_BYTES;

  kv_state_t state_q, state_d;

  logic [SHIFT_BITS-1:0]  carry_q;
  logic [SHIFT_BYTES-1:0] carry_keep_q;

  logic adv;
  logic in_fire;
  logic malformed;
  logic need_tail;
  logic load;
  logic carry_en;
  logic count_drop;

  logic [DATA_WIDTH-1:0] beat_data;
  logic [KEEP_WIDTH-1:0] beat_keep;
  logic                  beat_last;
  logic [HDR_BITS-1:0]   hdr;

  assign adv       = !m_axis_tvalid || m_axis_tready;
  assign in_fire   = s_axis_tvalid && s_axis_tready;
  assign malformed = (s_axis_tkeep[CLI_HDR_BYTES-1:0] != '1) ||
                     (s_axis_tdata[15:8] != KEYLEN_WORDS_OK);
  // Bytes above 51 spill past the shifted beat and need a follow-up tail beat.
  assign need_tail = |s_axis_tkeep[KEEP_WIDTH-1:CARRY_KLSB];
  assign hdr       = build_req_hdr(s_axis_tuser, s_axis_tdata[CLI_HDR_BITS-1:0]);

  always_comb begin
    case (state_q)
      ST_FIRST, ST_BODY: s_axis_tready = adv;
      ST_DROP:           s_axis_tready = 1'b1;
      default:           s_axis_tready = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    carry_en   = 1'b0;
    count_drop = 1'b0;
    beat_data  = '0;
    beat_keep  = '0;
    beat_last  = 1'b0;

    case (state_q)
      ST_FIRST: begin
        if (in_fire) begin
          if (malformed) begin
            count_drop = 1'b1;
            if (!s_axis_tlast) begin
              state_d = ST_DROP;
            end
          end else begin
            load      = 1'b1;
            carry_en  = 1'b1;
            beat_data = {s_axis_tdata[CARRY_LSB-1:CLI_HDR_BITS], hdr};
            beat_keep = {s_axis_tkeep[CARRY_KLSB-1:CLI_HDR_BYTES], {HDR_BYTES{1'b1}}};
            beat_last = s_axis_tlast && !need_tail;
            if (s_axis_tlast) begin
              state_d = need_tail ? ST_TAIL : ST_FIRST;
            end else begin
              state_d = ST_BODY;
            end
          end
        end
      end

      ST_BODY: begin
        if (in_fire) begin
          load      = 1'b1;
          carry_en  = 1'b1;
          beat_data = {s_axis_tdata[CARRY_LSB-1:0], carry_q};
          beat_keep = {s_axis_tkeep[CARRY_KLSB-1:0], carry_keep_q};
          beat_last = s_axis_tlast && !need_tail;
          if (s_axis_tlast) begin
            state_d = need_tail ? ST_TAIL : ST_FIRST;
          end
        end
      end

      ST_TAIL: begin
        if (adv) begin
          load      = 1'b1;
          beat_data = {{CARRY_LSB{1'b0}}, carry_q};
          beat_keep = {{CARRY_KLSB{1'b0}}, carry_keep_q};
          beat_last = 1'b1;
          state_d   = ST_FIRST;
        end
      end

      ST_DROP: begin
        if (in_fire && s_axis_tlast) begin
          state_d = ST_FIRST;
        end
      end

      default: state_d = ST_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_FIRST;
      carry_q       <= '0;
      carry_keep_q  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      drop_count    <= '0;
    end else begin
      state_q <= state_d;

      if (carry_en) begin
        carry_q      <= s_axis_tdata[DATA_WIDTH-1:CARRY_LSB];
        carry_keep_q <= s_axis_tkeep[KEEP_WIDTH-1:CARRY_KLSB];
      end

      if (adv) begin
        m_axis_tvalid <= load;
        if (load) begin
          m_axis_tdata <= beat_data;
          m_axis_tkeep <= beat_keep;
          m_axis_tlast <= beat_last;
        end
      end

      if (count_drop && (drop_count != '1)) begin
        drop_count <= drop_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_kv_request_framer.sv
// Directed bench for kv_request_framer: packets are built as byte streams and
// the expected output is the header followed by payload bytes 4.. of the input.
module tb_kv_request_framer;
  import kv_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tlast;
  logic [63:0]  s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [31:0]  drop_count;

  always #5 clk = ~clk;

  kv_request_framer #(.DATA_WIDTH(512), .META_WIDTH(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .drop_count    (drop_count)
  );

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  beat_t      cap_q[$];
  beat_t      exp_q[$];
  logic       rdy_pat[$];
  logic [7:0] pkt [0:255];
  int         pkt_len;
  beat_t      first_seen;
  beat_t      last_seen;
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_pat.size() > 0) m_axis_tready = rdy_pat.pop_front();
      else m_axis_tready = 1'b1;
    end
  end

  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n && m_axis_tvalid && m_axis_tready) begin
        b.data = m_axis_tdata;
        b.keep = m_axis_tkeep;
        b.last = m_axis_tlast;
        cap_q.push_back(b);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic mk_pkt(input int len, input logic [7:0] op, input logic [7:0] kl,
                        input logic [15:0] tl, input logic [7:0] seed);
    pkt_len = len;
    for (int i = 0; i < 256; i++) pkt[i] = (i < len) ? (8'(i * 3) ^ seed) : 8'h00;
    if (len > 0) pkt[0] = op;
    if (len > 1) pkt[1] = kl;
    if (len > 2) pkt[2] = tl[7:0];
    if (len > 3) pkt[3] = tl[15:8];
  endtask

  task automatic build_exp(input logic [63:0] user);
    logic [7:0] ob [0:319];
    int olen, nb;
    beat_t b;
    for (int i = 0; i < 320; i++) ob[i] = 8'h00;
    ob[0] = 8'hFF;
    ob[1] = 8'hFF;
    ob[4] = pkt[2];
    ob[5] = pkt[3];
    ob[6] = pkt[1];
    ob[7] = pkt[0];
    for (int i = 0; i < 8; i++) ob[8 + i] = user[8 * i +: 8];
    for (int i = 4; i < pkt_len; i++) ob[i + 12] = pkt[i];
    olen = pkt_len + 12;
    nb   = (olen + 63) / 64;
    for (int k = 0; k < nb; k++) begin
      b = '0;
      for (int j = 0; j < 64; j++) begin
        b.data[8 * j +: 8] = ob[64 * k + j];
        b.keep[j]          = (64 * k + j < olen);
      end
      b.last = (k == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l,
                           input logic [63:0] u, output int stalls);
    logic rdy;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    stalls = 0;
    forever begin
      @(negedge clk);
      rdy = s_axis_tready;
      @(posedge clk);
      #1;
      if (rdy) break;
      stalls++;
      if (stalls > 100) begin
        check("send_timeout", rdy, 1);
        break;
      end
    end
  endtask

  task automatic drive_pkt(input logic [63:0] user, input int max_beats,
                           input int drop_after_first, input bit chk_no_stall);
    int nb, st;
    logic [511:0] d;
    logic [63:0]  k;
    nb = (pkt_len + 63) / 64;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 64; j++) begin
        if (64 * b + j < pkt_len) begin
          d[8 * j +: 8] = pkt[64 * b + j];
          k[j] = 1'b1;
        end
      end
      send_beat(d, k, (b == nb - 1), (b == 0) ? user : 64'h0, st);
      if (b == 0 && drop_after_first >= 0) check("drop_on_first", drop_count, drop_after_first);
      if (chk_no_stall) check($sformatf("drop_rdy%0d", b), st, 0);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic check_out(input string tag);
    int n, waited;
    beat_t g, e;
    n = exp_q.size();
    waited = 0;
    while (cap_q.size() < n && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_beats"}, cap_q.size(), n);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (cap_q.size() > 0) begin
        g = cap_q.pop_front();
        if (i == 0) first_seen = g;
        last_seen = g;
        check($sformatf("%s_data%0d", tag, i), g.data, e.data);
        check($sformatf("%s_keep%0d", tag, i), g.keep, e.keep);
        check($sformatf("%s_last%0d", tag, i), g.last, e.last);
      end
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [63:0] tail_bytes;
    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tkeep", m_axis_tkeep, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_drop", drop_count, 0);
    check("rst_sready", s_axis_tready, 1);

    // Single-beat SET, 36 bytes, no tail
    mk_pkt(36, OP_SET, 8'h01, 16'h0004, 8'h5A);
    build_exp(64'h0A000001_1F90_2710);
    drive_pkt(64'h0A000001_1F90_2710, 99, -1, 0);
    check_out("set1");
    check("set1_hdr", first_seen.data[127:0], 128'h0A0000011F902710_01010004_0000FFFF);
    check("set1_keep", first_seen.keep, 64'h0000_FFFF_FFFF_FFFF);
    check("set1_last", first_seen.last, 1);

    // 60-byte single beat spills into a tail beat
    mk_pkt(60, OP_GET, 8'h01, 16'd15, 8'h33);
    build_exp(64'h0B000002_2000_3000);
    drive_pkt(64'h0B000002_2000_3000, 99, -1, 0);
    check_out("tail");
    for (int i = 0; i < 8; i++) tail_bytes[8 * i +: 8] = pkt[52 + i];
    check("tail_keep", last_seen.keep, 64'h0FF);
    check("tail_bytes", last_seen.data[63:0], tail_bytes);
    check("tail_tlast", last_seen.last, 1);

    // 3-beat packet under output backpressure
    mk_pkt(150, OP_SET, 8'h01, 16'd37, 8'hC3);
    build_exp(64'hC0A80001_1234_5678);
    rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b1);
    drive_pkt(64'hC0A80001_1234_5678, 99, -1, 0);
    check_out("bp3");

    // keylen=2 over 3 beats: swallowed, counted once on the first beat
    check("drop_pre", drop_count, 0);
    mk_pkt(150, OP_SET, 8'h02, 16'd37, 8'h71);
    drive_pkt(64'h1, 99, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    check("drop_noout", cap_q.size(), 0);
    check("drop_post", drop_count, 1);

    // Reset in the middle of a packet body
    mk_pkt(150, OP_GET, 8'h01, 16'd37, 8'h19);
    drive_pkt(64'h2, 2, -1, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_drop", drop_count, 0);
    rst_n = 1'b1;
    cap_q.delete();
    mk_pkt(100, OP_SET, 8'h01, 16'd22, 8'hE4);
    build_exp(64'h0A0A0A0A_0050_1F40);
    drive_pkt(64'h0A0A0A0A_0050_1F40, 99, -1, 0);
    check_out("post_rst");

    // 2-byte runt, then a clean 64-byte packet (which needs a tail)
    mk_pkt(2, OP_SET, 8'h01, 16'd0, 8'h00);
    drive_pkt(64'h3, 99, 1, 0);
    mk_pkt(64, OP_GET, 8'h01, 16'd13, 8'h8D);
    build_exp(64'hDEADBEEF_CAFE_F00D);
    drive_pkt(64'hDEADBEEF_CAFE_F00D, 99, -1, 0);
    check_out("after_runt");
    check("runt_drop", drop_count, 1);

    // Back-to-back packets: tail packet immediately followed by a short one
    mk_pkt(60, OP_SET, 8'h01, 16'd15, 8'h4C);
    build_exp(64'h11111111_2222_3333);
    drive_pkt(64'h11111111_2222_3333, 99, -1, 0);
    mk_pkt(36, OP_GET, 8'h01, 16'd9, 8'h27);
    build_exp(64'h44444444_5555_6666);
    drive_pkt(64'h44444444_5555_6666, 99, -1, 0);
    check_out("b2b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
